// File: rtl/imu.sv
// imu: 4-lane x 32-bit unsigned row scaled by a 32-bit scalar, 2-cycle pipeline.
// Optional build macro IMU_SATURATE_EN clamps overflowing lanes to 0xFFFFFFFF instead of wrapping.
module imu (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  value,
  input  logic [127:0] row,
  output logic [127:0] data,
  output logic         CBB_valid
);

  logic [31:0] value_reg;
  logic [1:0]  fill_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
      fill_reg  <= '0;
    end else begin
      value_reg <= value;
      fill_reg  <= {fill_reg[0], 1'b1};
    end
  end

  assign CBB_valid = fill_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [31:0] row_reg;
      logic [31:0] lane_reg;
      logic [31:0] lane_next;

`ifdef IMU_SATURATE_EN
      logic [63:0] product;
      always_comb begin
        product   = {32'd0, value_reg} * {32'd0, row_reg};
        lane_next = (|product[63:32]) ? 32'hFFFF_FFFF : product[31:0];
      end
`else
      // 32-bit context keeps only the low half: modulo 2^32 wrap.
      always_comb begin
        lane_next = value_reg * row_reg;
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          row_reg  <= '0;
          lane_reg <= '0;
        end else begin
          row_reg  <= row[32*gi +: 32];
          lane_reg <= lane_next;
        end
      end

      assign data[32*gi +: 32] = lane_reg;
    end
  endgenerate

endmodule

// File: tb/tb_imu.sv
// Directed self-checking bench for imu: reset, latency, streaming, lane independence, mid-run reset.
module tb_imu;

  logic         clk;
  logic         rst;
  logic [31:0]  value;
  logic [127:0] row;
  logic [127:0] data;
  logic         CBB_valid;

  int n_checks;
  int n_fails;

  imu dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .row       (row),
    .data      (data),
    .CBB_valid (CBB_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] ONES_ROW = {32'd1, 32'd1, 32'd1, 32'd1};

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset with arbitrary inputs.
    rst   = 1'b1;
    value = 32'hDEAD_BEEF;
    row   = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    #1 rst = 1'b0;
    #1;
    check("reset_async_data", data, 128'd0);
    check("reset_async_valid", {127'd0, CBB_valid}, 128'd1 - 128'd1);
    tick();
    check("reset_hold1_data", data, 128'd0);
    check("reset_hold1_valid", {127'd0, CBB_valid}, 128'd0);
    tick();
    check("reset_hold2_data", data, 128'd0);
    check("reset_hold2_valid", {127'd0, CBB_valid}, 128'd0);

    // Release and basic scaling.
    rst   = 1'b1;
    value = 32'd5;
    row   = {32'd3, 32'd2, 32'd1, 32'd0};
    tick();
    check("release_edge1_valid", {127'd0, CBB_valid}, 128'd0);
    check("release_edge1_data", data, 128'd0);
    tick();
    check("release_edge2_valid", {127'd0, CBB_valid}, 128'd1);
    check("basic_data", data, 128'h0000000F_0000000A_00000005_00000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_stable", data, 128'h0000000F_0000000A_00000005_00000000);
    end
    check("basic_valid_held", {127'd0, CBB_valid}, 128'd1);

    // Streaming: value 1,2,3 back-to-back over row of ones.
    row   = ONES_ROW;
    value = 32'd1;
    tick();
    check("stream_latency_old", data, 128'h0000000F_0000000A_00000005_00000000);
    value = 32'd2;
    tick();
    check("stream_v1", data, ONES_ROW);
    value = 32'd3;
    tick();
    check("stream_v2", data, {4{32'd2}});
    tick();
    check("stream_v3", data, {4{32'd3}});

    // Lane independence with one overflowing lane.
    value = 32'd7;
    row   = {32'h10, 32'd1, 32'd0, 32'hFFFF_FFFF};
    tick();
    tick();
`ifdef IMU_SATURATE_EN
    check("lane_indep", data, {32'h70, 32'd7, 32'd0, 32'hFFFF_FFFF});
`else
    check("lane_indep", data, {32'h70, 32'd7, 32'd0, 32'hFFFF_FFF9});
`endif

    // value = 0 zeroes every lane; value = 1 passes the row through.
    value = 32'd0;
    row   = {32'hCAFE_F00D, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    tick();
    tick();
    check("value_zero", data, 128'd0);
    value = 32'd1;
    tick();
    tick();
    check("value_one_passthru", data, {32'hCAFE_F00D, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF});

    // Large multiplier wrap (or clamp) on one lane, small product elsewhere.
    value = 32'h8000_0000;
    row   = {32'd2, 32'd1, 32'd0, 32'd3};
    tick();
    tick();
`ifdef IMU_SATURATE_EN
    check("big_value", data, {32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF});
`else
    check("big_value", data, {32'd0, 32'h8000_0000, 32'd0, 32'h8000_0000});
`endif

    // Mid-run reset: asserted between edges, outputs must clear at once.
    value = 32'd4;
    row   = ONES_ROW;
    tick();
    tick();
    check("pre_midreset_data", data, {4{32'd4}});
    #3 rst = 1'b0;
    #1;
    check("midreset_async_data", data, 128'd0);
    check("midreset_async_valid", {127'd0, CBB_valid}, 128'd0);
    tick();
    check("midreset_hold_data", data, 128'd0);
    rst   = 1'b1;
    value = 32'd2;
    tick();
    check("midrel_edge1_valid", {127'd0, CBB_valid}, 128'd0);
    check("midrel_edge1_data", data, 128'd0);
    tick();
    check("midrel_edge2_valid", {127'd0, CBB_valid}, 128'd1);
    check("midrel_edge2_data", data, {4{32'd2}});
    tick();
    check("midrel_valid_stays", {127'd0, CBB_valid}, 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
